knockout_scheduler: RTL and testbench

KNOCKOUT_SCHEDULER -- requirements
Module: knockout_scheduler

---
 rtl/knockout_scheduler.sv | 164 ++++++++++++++++
 tb/tb_knockout_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/knockout_scheduler.sv
// Four-team single-elimination scheduler: presents SF1, SF2 and the final in turn,
// records each outcome and reports the champion with a one-cycle done pulse.
module knockout_scheduler #(
  parameter int unsigned TEAM_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [TEAM_W-1:0] a,
  input  logic [TEAM_W-1:0] b,
  input  logic [TEAM_W-1:0] c,
  input  logic [TEAM_W-1:0] d,
  output logic              match_valid,
  output logic [1:0]        match_id,
  output logic [TEAM_W-1:0] team_one,
  output logic [TEAM_W-1:0] team_two,
  input  logic              result_valid,
  input  logic              result,
  output logic [2:0]        sel,
  output logic [TEAM_W-1:0] champion,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SF1, SF2, FINAL} state_t;

  state_t            state, state_n;
  logic [TEAM_W-1:0] ca, cb, cc, cd, w1, w2;
  logic [TEAM_W-1:0] ca_n, cb_n, cc_n, cd_n, w1_n, w2_n;
  logic              match_valid_n, busy_n, done_n;
  logic [1:0]        match_id_n;
  logic [TEAM_W-1:0] team_one_n, team_two_n, champion_n;
  logic [2:0]        sel_n;
  logic              accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Outputs are registered from the next-state view so the next match appears
  // on the cycle right after acceptance with no gap.
  always_comb begin
    state_n    = state;
    ca_n       = ca;
    cb_n       = cb;
    cc_n       = cc;
    cd_n       = cd;
    w1_n       = w1;
    w2_n       = w2;
    sel_n      = sel;
    champion_n = champion;
    done_n     = 1'b0;
    accept     = match_valid & result_valid;

    unique case (state)
      IDLE: begin
        if (!abort && start) begin
          state_n = SF1;
          ca_n    = a;
          cb_n    = b;
          cc_n    = c;
          cd_n    = d;
          sel_n   = '0;
        end
      end
      SF1: begin
        if (abort) begin
          state_n = IDLE;
        end else if (accept) begin
          sel_n[0] = result;
          w1_n     = result ? cb : ca;
          state_n  = SF2;
        end
      end
      SF2: begin
        if (abort) begin
          state_n = IDLE;
        end else if (accept) begin
          sel_n[1] = result;
          w2_n     = result ? cd : cc;
          state_n  = FINAL;
        end
      end
      FINAL: begin
        if (abort) begin
          state_n = IDLE;
        end else if (accept) begin
          sel_n[2]   = result;
          champion_n = result ? w2 : w1;
          done_n     = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    match_valid_n = 1'b0;
    match_id_n    = 2'd0;
    team_one_n    = '0;
    team_two_n    = '0;
    case (state_n)
      SF1: begin
        match_valid_n = 1'b1;
        match_id_n    = 2'd0;
        team_one_n    = ca_n;
        team_two_n    = cb_n;
      end
      SF2: begin
        match_valid_n = 1'b1;
        match_id_n    = 2'd1;
        team_one_n    = cc_n;
        team_two_n    = cd_n;
      end
      FINAL: begin
        match_valid_n = 1'b1;
        match_id_n    = 2'd2;
        team_one_n    = w1_n;
        team_two_n    = w2_n;
      end
      default: ;
    endcase
    busy_n = match_valid_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ca          <= '0;
      cb          <= '0;
      cc          <= '0;
      cd          <= '0;
      w1          <= '0;
      w2          <= '0;
      match_valid <= 1'b0;
      match_id    <= 2'd0;
      team_one    <= '0;
      team_two    <= '0;
      sel         <= '0;
      champion    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      ca          <= ca_n;
      cb          <= cb_n;
      cc          <= cc_n;
      cd          <= cd_n;
      w1          <= w1_n;
      w2          <= w2_n;
      match_valid <= match_valid_n;
      match_id    <= match_id_n;
      team_one    <= team_one_n;
      team_two    <= team_two_n;
      sel         <= sel_n;
      champion    <= champion_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

endmodule

// File: tb/tb_knockout_scheduler.sv
// Directed bench for knockout_scheduler: expected matches are queued when a
// tournament is launched and popped as the DUT presents each match.
module tb_knockout_scheduler;

  localparam int unsigned W = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] a = '0, b = '0, c = '0, d = '0;
  logic         match_valid;
  logic [1:0]   match_id;
  logic [W-1:0] team_one, team_two;
  logic         result_valid = 1'b0;
  logic         result = 1'b0;
  logic [2:0]   sel;
  logic [W-1:0] champion;
  logic         busy;
  logic         done;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] t1;
    logic [W-1:0] t2;
  } match_t;

  match_t       sbq[$];
  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] last_champ = '0;

  knockout_scheduler #(.TEAM_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a(a), .b(b), .c(c), .d(d),
    .match_valid(match_valid), .match_id(match_id),
    .team_one(team_one), .team_two(team_two),
    .result_valid(result_valid), .result(result),
    .sel(sel), .champion(champion), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_match(input string tag, input match_t m);
    check({tag, ".mv"},   {31'd0, match_valid}, 32'd1);
    check({tag, ".busy"}, {31'd0, busy},        32'd1);
    check({tag, ".id"},   {30'd0, match_id},    {30'd0, m.id});
    check({tag, ".t1"},   {{(32-W){1'b0}}, team_one}, {{(32-W){1'b0}}, m.t1});
    check({tag, ".t2"},   {{(32-W){1'b0}}, team_two}, {{(32-W){1'b0}}, m.t2});
  endtask

  // Runs one tournament; dly = idle cycles before each result, hold = result_valid
  // kept high from start, abrt = abort together with the final result.
  task automatic run_tourn(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [W-1:0] tc,
                           input logic [W-1:0] td, input logic [2:0] r, input int unsigned dly,
                           input bit hold, input bit abrt);
    logic [W-1:0] w1, w2, ch;
    match_t       m;
    int           cyc;
    w1 = r[0] ? tb_ : ta;
    w2 = r[1] ? td : tc;
    ch = r[2] ? w2 : w1;
    sbq.push_back('{id: 2'd0, t1: ta, t2: tb_});
    sbq.push_back('{id: 2'd1, t1: tc, t2: td});
    sbq.push_back('{id: 2'd2, t1: w1, t2: w2});
    a = ta; b = tb_; c = tc; d = td;
    start = 1'b1;
    if (hold) begin
      result_valid = 1'b1;
      result = r[0];
    end
    tick();
    start = 1'b0;
    cyc = 1;
    if (hold) begin
      a = ~ta; b = ~tb_; c = ~tc; d = ~td;
    end
    for (int k = 0; k < 3; k++) begin
      m = sbq.pop_front();
      for (int unsigned w = 0; w < dly; w++) begin
        check_match("wait", m);
        check("wait.done", {31'd0, done}, 32'd0);
        tick();
        cyc++;
      end
      check_match("match", m);
      result_valid = 1'b1;
      result = r[k];
      if (abrt && k == 2) abort = 1'b1;
      tick();
      cyc++;
      abort = 1'b0;
      if (!hold) result_valid = 1'b0;
    end
    check("end.mv",   {31'd0, match_valid}, 32'd0);
    check("end.busy", {31'd0, busy},        32'd0);
    if (abrt) begin
      check("abort.done",  {31'd0, done}, 32'd0);
      check("abort.champ", {{(32-W){1'b0}}, champion}, {{(32-W){1'b0}}, last_champ});
    end else begin
      check("end.done",  {31'd0, done}, 32'd1);
      check("end.champ", {{(32-W){1'b0}}, champion}, {{(32-W){1'b0}}, ch});
      check("end.sel",   {29'd0, sel}, {29'd0, r});
      if (dly == 0) check("end.latency", cyc, 32'd4);
      last_champ = ch;
    end
    tick();
    result_valid = 1'b0;
    check("after.done",  {31'd0, done},        32'd0);
    check("after.mv",    {31'd0, match_valid}, 32'd0);
    check("after.champ", {{(32-W){1'b0}}, champion}, {{(32-W){1'b0}}, last_champ});
    if (!abrt) check("after.sel", {29'd0, sel}, {29'd0, r});
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".mv"},    {31'd0, match_valid}, 32'd0);
    check({tag, ".id"},    {30'd0, match_id},    32'd0);
    check({tag, ".t1"},    {{(32-W){1'b0}}, team_one}, 32'd0);
    check({tag, ".t2"},    {{(32-W){1'b0}}, team_two}, 32'd0);
    check({tag, ".sel"},   {29'd0, sel},          32'd0);
    check({tag, ".champ"}, {{(32-W){1'b0}}, champion}, 32'd0);
    check({tag, ".busy"},  {31'd0, busy},         32'd0);
    check({tag, ".done"},  {31'd0, done},         32'd0);
  endtask

  initial begin
    #12;
    check_reset("reset");
    rst_n = 1'b1;
    tick();
    tick();
    check("rel.idle", {31'd0, busy}, 32'd0);

    // Result with no match presented, and abort beating start in IDLE.
    result_valid = 1'b1;
    result = 1'b1;
    tick();
    result_valid = 1'b0;
    check("stray.sel", {29'd0, sel}, 32'd0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abortstart.mv", {31'd0, match_valid}, 32'd0);

    run_tourn(2'd0, 2'd1, 2'd2, 2'd3, 3'b101, 0, 1'b0, 1'b0);
    run_tourn(2'd0, 2'd1, 2'd2, 2'd3, 3'b010, 3, 1'b0, 1'b0);
    run_tourn(2'd0, 2'd1, 2'd2, 2'd3, 3'b111, 0, 1'b1, 1'b0);
    run_tourn(2'd3, 2'd2, 2'd1, 2'd0, 3'b001, 0, 1'b0, 1'b1);
    run_tourn(2'd3, 2'd2, 2'd1, 2'd0, 3'b110, 1, 1'b0, 1'b0);

    // Start during SF1 is ignored; async reset mid-SF2.
    a = 2'd1; b = 2'd2; c = 2'd3; d = 2'd0;
    start = 1'b1;
    tick();
    a = 2'd3; b = 2'd3; c = 2'd1; d = 2'd1;
    check_match("sf1", '{id: 2'd0, t1: 2'd1, t2: 2'd2});
    tick();
    start = 1'b0;
    check_match("nostart", '{id: 2'd0, t1: 2'd1, t2: 2'd2});
    result_valid = 1'b1;
    result = 1'b0;
    tick();
    result_valid = 1'b0;
    check_match("sf2", '{id: 2'd1, t1: 2'd3, t2: 2'd0});
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    check("postrst.mv", {31'd0, match_valid}, 32'd0);
    check("sbq.empty", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
